// File: rtl/core_seq_pkg.sv
// Shared constants for the ROM-driven micro-sequencer: opcodes, FSM state
// encoding and instruction-word layout helpers.
package core_seq_pkg;

  localparam int OPC_W = 4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SUBI = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_JZ   = 4'd5;
  localparam logic [3:0] OP_JN   = 4'd6;
  localparam logic [3:0] OP_OUT  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  localparam logic [1:0] ST_WAIT_TICK = 2'd0;
  localparam logic [1:0] ST_FETCH     = 2'd1;
  localparam logic [1:0] ST_EXEC      = 2'd2;
  localparam logic [1:0] ST_HALT      = 2'd3;

  // Instruction word is {opcode, immediate}; opcode sits directly above the immediate.
  function automatic int instr_w(input int data_w);
    return OPC_W + data_w;
  endfunction

  function automatic int opc_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/core_seq_rom.sv
// Tick-paced micro-sequencer executing one ROM instruction per tick on a signed
// accumulator. Define CORE_SEQ_ROM_SAT_EN to saturate ADDI/SUBI on overflow.
module core_seq_rom
  import core_seq_pkg::*;
#(
  parameter int DATA_W   = 15,
  parameter int PC_W     = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic                         CLK_50,
  input  logic                         rst_n,
  output logic [PC_W-1:0]              rom_addr,
  input  logic [instr_w(DATA_W)-1:0]   rom_data,
  output logic [DATA_W-1:0]            out_val,
  output logic                         out_sign,
  output logic                         out_strobe,
  output logic [PC_W-1:0]              pc,
  output logic                         halted,
  output logic                         ovf,
  output logic [1:0]                   state_dbg
);

  if (TICK_DIV < 3) begin : g_bad_tick_div
    $error("core_seq_rom: TICK_DIV must be >= 3");
  end

  logic              tick;
  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic              out_strobe_q, out_strobe_d;
  logic              ovf_q, ovf_d;

  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   target;
  logic [DATA_W-1:0] sum, diff, add_res, sub_res;
  logic              add_ovf, sub_ovf;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_i   (CLK_50),
    .rst_n_i (rst_n),
    .tick_o  (tick)
  );

  assign opc    = rom_data[opc_lsb(DATA_W) +: OPC_W];
  assign imm    = rom_data[DATA_W-1:0];
  assign target = imm[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);

  // Overflow: operands (after negating imm for SUBI) share a sign the result lacks.
  assign sum     = acc_q + imm;
  assign diff    = acc_q - imm;
  assign add_ovf = (acc_q[DATA_W-1] == imm[DATA_W-1]) && (sum[DATA_W-1]  != acc_q[DATA_W-1]);
  assign sub_ovf = (acc_q[DATA_W-1] != imm[DATA_W-1]) && (diff[DATA_W-1] != acc_q[DATA_W-1]);

`ifdef CORE_SEQ_ROM_SAT_EN
  logic [DATA_W-1:0] sat_val;
  // An overflowed result always lies beyond the limit on the accumulator's side.
  assign sat_val = acc_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign add_res = add_ovf ? sat_val : sum;
  assign sub_res = sub_ovf ? sat_val : diff;
`else
  assign add_res = sum;
  assign sub_res = diff;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    out_val_d    = out_val_q;
    out_strobe_d = 1'b0;
    ovf_d        = ovf_q;
    case (state_q)
      ST_WAIT_TICK: if (tick) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WAIT_TICK;
        pc_d    = pc_inc;
        case (opc)
          OP_NOP:  ;
          OP_LDI:  acc_d = imm;
          OP_ADDI: begin acc_d = add_res; ovf_d = ovf_q | add_ovf; end
          OP_SUBI: begin acc_d = sub_res; ovf_d = ovf_q | sub_ovf; end
          OP_JMP:  pc_d = target;
          OP_JZ:   if (acc_q == '0) pc_d = target;
          OP_JN:   if (acc_q[DATA_W-1]) pc_d = target;
          OP_OUT:  begin out_val_d = acc_q; out_strobe_d = 1'b1; end
          OP_HALT: begin state_d = ST_HALT; pc_d = pc_q; end
          default: ;
        endcase
      end
      ST_HALT:  ;
      default:  state_d = ST_WAIT_TICK;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_TICK;
      pc_q         <= '0;
      acc_q        <= '0;
      out_val_q    <= '0;
      out_strobe_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      out_val_q    <= out_val_d;
      out_strobe_q <= out_strobe_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign out_val    = out_val_q;
  assign out_sign   = out_val_q[DATA_W-1];
  assign out_strobe = out_strobe_q;
  assign halted     = (state_q == ST_HALT);
  assign ovf        = ovf_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_core_seq_rom.sv
// Bench for core_seq_rom: directed programs plus random programs checked
// against an instruction-level interpreter of the program.
module tb_core_seq_rom;

  localparam int DW = 15;
  localparam int PW = 4;
  localparam int TD = 4;
  localparam int MAXV = 16383;
  localparam int MINV = -16384;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] rom_addr;
  logic [DW+3:0] rom_data;
  logic [DW-1:0] out_val;
  logic          out_sign;
  logic          out_strobe;
  logic [PW-1:0] pc;
  logic          halted;
  logic          ovf;
  logic [1:0]    state_dbg;

  logic [DW+3:0] rom [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs_q [$];

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] m_pc;
  logic          m_halt;
  logic          m_ovf;
  logic [DW-1:0] m_out;

  core_seq_rom #(.DATA_W(DW), .PC_W(PW), .TICK_DIV(TD)) dut (
    .CLK_50     (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_val    (out_val),
    .out_sign   (out_sign),
    .out_strobe (out_strobe),
    .pc         (pc),
    .halted     (halted),
    .ovf        (ovf),
    .state_dbg  (state_dbg)
  );

  // Clock / synchronous ROM / strobe monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) if (rst_n === 1'b1 && out_strobe === 1'b1) obs_q.push_back(out_val);

  // Driver tasks
  task automatic set_instr(input int addr, input int op, input int imm);
    logic [3:0]    o;
    logic [DW-1:0] i;
    o = op[3:0];
    i = imm[DW-1:0];
    rom[addr] = {o, i};
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 16; a++) rom[a] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    obs_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the sim 1 time unit after the k-th instruction's EXEC edge.
  task automatic dut_run(input int k);
    do_reset();
    repeat (4 * k + 2) @(posedge clk);
    #1;
  endtask

  // Instruction-level interpreter over the ROM contents.
  task automatic model_run(input int k);
    int acc, p, imm, r;
    logic [3:0] op;
    logic signed [DW-1:0] imm_s;
    logic [DW-1:0] accb;
    exp_q.delete();
    m_ovf = 1'b0; m_halt = 1'b0; m_out = '0;
    acc = 0; p = 0;
    for (int n = 0; n < k && !m_halt; n++) begin
      op = rom[p][DW+3:DW];
      imm_s = rom[p][DW-1:0];
      imm = imm_s;
      case (op)
        4'd1: begin acc = imm; p = (p + 1) % 16; end
        4'd2, 4'd3: begin
          r = (op == 4'd2) ? acc + imm : acc - imm;
          if (r > MAXV || r < MINV) begin
            m_ovf = 1'b1;
`ifdef CORE_SEQ_ROM_SAT_EN
            r = (r > MAXV) ? MAXV : MINV;
`else
            r = (r > MAXV) ? r - 32768 : r + 32768;
`endif
          end
          acc = r;
          p = (p + 1) % 16;
        end
        4'd4: p = imm & 15;
        4'd5: p = (acc == 0) ? (imm & 15) : (p + 1) % 16;
        4'd6: p = (acc < 0) ? (imm & 15) : (p + 1) % 16;
        4'd7: begin accb = acc[DW-1:0]; exp_q.push_back(accb); m_out = accb; p = (p + 1) % 16; end
        4'd8: m_halt = 1'b1;
        default: p = (p + 1) % 16;
      endcase
    end
    m_pc = p[PW-1:0];
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (rom_addr !== 4'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    checks++; if (out_val !== 15'd0 || out_strobe !== 1'b0) begin failures++; $display("FAIL reset_out got=%0d/%0b exp=0/0", out_val, out_strobe); end
    checks++; if (halted !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b/%0b exp=0/0", halted, ovf); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_add_out();
    clear_rom();
    set_instr(0, 1, 5); set_instr(1, 2, 7); set_instr(2, 7, 0); set_instr(3, 8, 0);
    do_reset();
    repeat (5) @(posedge clk); #1;
    checks++; if (pc !== 4'd0 || state_dbg !== 2'd2) begin failures++; $display("FAIL t1_pre_exec got pc=%0d st=%0d exp pc=0 st=2", pc, state_dbg); end
    @(posedge clk); #1;
    checks++; if (pc !== 4'd1 || state_dbg !== 2'd0) begin failures++; $display("FAIL t1_first_exec got pc=%0d st=%0d exp pc=1 st=0", pc, state_dbg); end
    repeat (12) @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || pc !== 4'd3) begin failures++; $display("FAIL t1_halt got h=%0b pc=%0d exp h=1 pc=3", halted, pc); end
    repeat (8) @(posedge clk); #1;
    checks++; if (out_val !== 15'd12 || obs_q.size() != 1) begin failures++; $display("FAIL t1_out got=%0d strobes=%0d exp=12 strobes=1", out_val, obs_q.size()); end
    checks++; if (pc !== 4'd3 || halted !== 1'b1) begin failures++; $display("FAIL t1_frozen got pc=%0d h=%0b exp pc=3 h=1", pc, halted); end
  endtask

  task automatic test_jn();
    clear_rom();
    set_instr(0, 1, 3); set_instr(1, 3, 10); set_instr(2, 6, 4);
    set_instr(3, 8, 0); set_instr(4, 7, 0); set_instr(5, 8, 0);
    dut_run(5);
    @(negedge clk); @(negedge clk);
    checks++; if (out_val !== 15'h7FF9 || out_sign !== 1'b1) begin failures++; $display("FAIL t2_out got=%h sign=%0b exp=7ff9 sign=1", out_val, out_sign); end
    checks++; if (pc !== 4'd5 || halted !== 1'b1) begin failures++; $display("FAIL t2_pc got pc=%0d h=%0b exp pc=5 h=1", pc, halted); end
  endtask

  task automatic test_loop_jz();
    clear_rom();
    set_instr(0, 1, 3); set_instr(1, 3, 1); set_instr(2, 5, 4);
    set_instr(3, 4, 1); set_instr(4, 7, 0); set_instr(5, 8, 0);
    dut_run(10);
    checks++; if (halted !== 1'b0 || pc !== 4'd5) begin failures++; $display("FAIL t3_before_halt got h=%0b pc=%0d exp h=0 pc=5", halted, pc); end
    repeat (4) @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || pc !== 4'd5) begin failures++; $display("FAIL t3_halt got h=%0b pc=%0d exp h=1 pc=5", halted, pc); end
    checks++; if (out_val !== 15'd0 || obs_q.size() != 1) begin failures++; $display("FAIL t3_out got=%0d strobes=%0d exp=0 strobes=1", out_val, obs_q.size()); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_v;
`ifdef CORE_SEQ_ROM_SAT_EN
    exp_v = 15'd16383;
`else
    exp_v = 15'h4000;
`endif
    clear_rom();
    set_instr(0, 1, 16383); set_instr(1, 2, 1); set_instr(2, 7, 0);
    dut_run(3);
    @(negedge clk); @(negedge clk);
    checks++; if (out_val !== exp_v) begin failures++; $display("FAIL t4_out got=%h exp=%h", out_val, exp_v); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL t4_ovf got=%0b exp=1", ovf); end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    set_instr(9, 12, 0);
    dut_run(16);
    checks++; if (pc !== 4'd0 || halted !== 1'b0) begin failures++; $display("FAIL t5_wrap got pc=%0d h=%0b exp pc=0 h=0", pc, halted); end
    repeat (4) @(posedge clk); #1;
    checks++; if (pc !== 4'd1 || halted !== 1'b0) begin failures++; $display("FAIL t5_continue got pc=%0d h=%0b exp pc=1 h=0", pc, halted); end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    set_instr(0, 1, 9); set_instr(1, 2, 1); set_instr(2, 7, 0); set_instr(3, 8, 0);
    do_reset();
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (pc !== 4'd0 || rom_addr !== 4'd0 || out_strobe !== 1'b0) begin failures++; $display("FAIL t6_reset got pc=%0d addr=%0d strobe=%0b exp 0/0/0", pc, rom_addr, out_strobe); end
    checks++; if (state_dbg !== 2'd0 || ovf !== 1'b0) begin failures++; $display("FAIL t6_state got st=%0d ovf=%0b exp 0/0", state_dbg, ovf); end
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (18) @(posedge clk); #1;
    @(negedge clk); @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 4'd3) begin failures++; $display("FAIL t6_restart got h=%0b pc=%0d exp h=1 pc=3", halted, pc); end
    checks++; if (out_val !== 15'd10 || obs_q.size() != 1) begin failures++; $display("FAIL t6_out got=%0d strobes=%0d exp=10 strobes=1", out_val, obs_q.size()); end
  endtask

  task automatic test_random();
    int k, op, imm, n;
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 16; a++) begin
        op = $urandom_range(0, 15);
        if (op == 8 && $urandom_range(0, 2) != 0) op = 7;
        if (op >= 4 && op <= 6) imm = $urandom_range(0, 15);
        else if ($urandom_range(0, 4) == 0) imm = $urandom_range(0, 32767) - 16384;
        else imm = $urandom_range(0, 40) - 20;
        set_instr(a, op, imm);
      end
      k = $urandom_range(8, 24);
      model_run(k);
      dut_run(k);
      checks++; if (pc !== m_pc || rom_addr !== m_pc) begin failures++; $display("FAIL rnd%0d_pc got=%0d addr=%0d exp=%0d", t, pc, rom_addr, m_pc); end
      checks++; if (halted !== m_halt || ovf !== m_ovf) begin failures++; $display("FAIL rnd%0d_flags got h=%0b o=%0b exp h=%0b o=%0b", t, halted, ovf, m_halt, m_ovf); end
      @(negedge clk); @(negedge clk);
      checks++; if (out_val !== m_out) begin failures++; $display("FAIL rnd%0d_outval got=%h exp=%h", t, out_val, m_out); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int j = 0; j < n; j++) begin
        checks++; if (obs_q[j] !== exp_q[j]) begin failures++; $display("FAIL rnd%0d_out%0d got=%h exp=%h", t, j, obs_q[j], exp_q[j]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_rom();
    test_reset();
    test_add_out();
    test_jn();
    test_loop_jz();
    test_overflow();
    test_pc_wrap();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
